// File: rtl/fetch_pair_tracker_if.sv
// Instruction-read channel bundle (address and data handshakes).
// The master side drives the channel; the slave side is a passive
// observer that only samples every signal.
interface fetch_pair_tracker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ir_addr_valid;
  logic                  ir_addr_ready;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic                  ir_data_valid;
  logic                  ir_data_ready;
  logic [DATA_WIDTH-1:0] ir_data;

  modport master (
    output ir_addr_valid, ir_addr_ready, ir_addr,
    output ir_data_valid, ir_data_ready, ir_data
  );

  modport slave (
    input ir_addr_valid, ir_addr_ready, ir_addr,
    input ir_data_valid, ir_data_ready, ir_data
  );
endinterface

// File: rtl/fetch_pair_tracker.sv
// Passive fetch tracker: snoops the instruction-read channel, queues
// accepted fetch addresses in order and pairs each returned word with
// its address, emitting one registered record per completed fetch.
// Also counts completed fetches and flags overflow/underflow of the
// outstanding-request queue.
module fetch_pair_tracker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_pair_tracker_if.slave      ir,
  input  logic                     err_clear,
  output logic                     fetch_valid,
  output logic [ADDR_WIDTH-1:0]    fetch_addr,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_WIDTH-1:0]     fetch_count,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OUT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic push;
  logic pop;
  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic overflow_event;
  logic underflow_event;

  // Handshake decode and queue-state classification for this cycle.
  // A pop only ever pairs with an entry already present, so a full
  // queue can still accept a push when the head leaves in the same cycle.
  always_comb begin
    push            = ir.ir_addr_valid & ir.ir_addr_ready;
    pop             = ir.ir_data_valid & ir.ir_data_ready;
    empty           = (outstanding == '0);
    full            = (outstanding == OUT_W'(DEPTH));
    do_pop          = pop & ~empty;
    do_push         = push & (~full | do_pop);
    overflow_event  = push & full & ~do_pop;
    underflow_event = pop & empty;
  end

  // Address storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= ir.ir_addr;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered fetch record and saturating completed-fetch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid <= 1'b0;
      fetch_addr  <= '0;
      fetch_data  <= '0;
      fetch_count <= '0;
    end else begin
      fetch_valid <= do_pop;
      if (do_pop) begin
        fetch_addr <= addr_mem[rd_ptr];
        fetch_data <= ir.ir_data;
        if (fetch_count != '1) begin
          fetch_count <= fetch_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Sticky protocol-error flags; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (overflow_event)  err_overflow <= 1'b1;
      else if (err_clear)  err_overflow <= 1'b0;
      if (underflow_event) err_underflow <= 1'b1;
      else if (err_clear)  err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pair_tracker.sv
// Self-checking bench for fetch_pair_tracker: directed scenarios followed
// by randomized channel traffic, scored against a queue-based reference.
module tb_fetch_pair_tracker;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_clear;
  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] fetch_count;
  logic          err_overflow;
  logic          err_underflow;

  fetch_pair_tracker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ir_bus ();

  fetch_pair_tracker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ir            (ir_bus),
    .err_clear     (err_clear),
    .fetch_valid   (fetch_valid),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .outstanding   (outstanding),
    .fetch_count   (fetch_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rec_t;

  // Reference model state
  logic [AW-1:0] m_q[$];
  rec_t          exp_q[$];
  bit            m_pulse;
  int            m_cnt;
  bit            m_ovf;
  bit            m_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of channel activity, then advance the model across the edge.
  task automatic apply_stimulus(input bit av, input bit ar, input logic [AW-1:0] a,
                                input bit dv, input bit dr, input logic [DW-1:0] d,
                                input bit clr);
    int   sz0;
    bit   push, pop, ovf_ev, unf_ev;
    rec_t r;
    ir_bus.ir_addr_valid = av;
    ir_bus.ir_addr_ready = ar;
    ir_bus.ir_addr       = a;
    ir_bus.ir_data_valid = dv;
    ir_bus.ir_data_ready = dr;
    ir_bus.ir_data       = d;
    err_clear            = clr;
    @(posedge clk);
    sz0    = m_q.size();
    push   = av & ar;
    pop    = dv & dr;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    m_pulse = 1'b0;
    if (pop) begin
      if (sz0 == 0) begin
        unf_ev = 1'b1;
      end else begin
        r.a = m_q.pop_front();
        r.d = d;
        exp_q.push_back(r);
        m_pulse = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    if (push) begin
      if (sz0 == DEPTH && !pop) ovf_ev = 1'b1;
      else m_q.push_back(a);
    end
    m_ovf = ovf_ev | (m_ovf & !clr);
    m_unf = unf_ev | (m_unf & !clr);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ir_bus.ir_addr_valid = 1'b0;
    ir_bus.ir_addr_ready = 1'b0;
    ir_bus.ir_data_valid = 1'b0;
    ir_bus.ir_data_ready = 1'b0;
    err_clear = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_pulse = 1'b0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    #1;
    check_output("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check_output("rst_fetch_addr", 64'(fetch_addr), 64'd0);
    check_output("rst_fetch_data", 64'(fetch_data), 64'd0);
    check_output("rst_outstanding", 64'(outstanding), 64'd0);
    check_output("rst_fetch_count", 64'(fetch_count), 64'd0);
    check_output("rst_err_ovf", 64'(err_overflow), 64'd0);
    check_output("rst_err_unf", 64'(err_underflow), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compares DUT state against the model and pops records as they appear.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      check_output("fetch_valid", 64'(fetch_valid), 64'(m_pulse));
      check_output("outstanding", 64'(outstanding), 64'(m_q.size()));
      check_output("fetch_count", 64'(fetch_count), 64'(m_cnt));
      check_output("err_overflow", 64'(err_overflow), 64'(m_ovf));
      check_output("err_underflow", 64'(err_underflow), 64'(m_unf));
      if (fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_record: got addr %0h data %0h expected none", fetch_addr, fetch_data);
        end else begin
          e = exp_q.pop_front();
          check_output("fetch_addr", 64'(fetch_addr), 64'(e.a));
          check_output("fetch_data", 64'(fetch_data), 64'(e.d));
        end
      end
    end
  end

  initial begin
    int pops_left;
    #1;
    do_reset();
    idle(2);

    $display("[TB] single fetch");
    apply_stimulus(1, 1, 32'h0, 0, 0, '0, 0);
    idle(1);
    apply_stimulus(0, 0, '0, 1, 1, 32'h93, 0);
    idle(2);

    $display("[TB] pipelined fetches");
    apply_stimulus(1, 1, 32'h0, 0, 0, '0, 0);
    apply_stimulus(1, 1, 32'h4, 0, 0, '0, 0);
    apply_stimulus(1, 1, 32'h8, 0, 0, '0, 0);
    apply_stimulus(0, 0, '0, 1, 1, 32'h11, 0);
    apply_stimulus(0, 0, '0, 1, 1, 32'h22, 0);
    apply_stimulus(0, 0, '0, 1, 1, 32'h33, 0);
    idle(2);

    $display("[TB] full queue overflow");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 1, 32'(4 * i), 0, 0, '0, 0);
    apply_stimulus(1, 1, 32'h10, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 0, '0, 1, 1, 32'(32'hA0 + i), 0);
    idle(1);
    apply_stimulus(0, 0, '0, 0, 0, '0, 1);
    idle(1);

    $display("[TB] full queue push plus pop");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 1, 32'(4 * i), 0, 0, '0, 0);
    apply_stimulus(1, 1, 32'h10, 1, 1, 32'hB0, 0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 0, '0, 1, 1, 32'(32'hB1 + i), 0);
    idle(2);

    $display("[TB] underflow with simultaneous push");
    apply_stimulus(1, 1, 32'h20, 1, 1, 32'hDEADBEEF, 0);
    apply_stimulus(0, 0, '0, 1, 1, 32'h55, 0);
    idle(1);
    apply_stimulus(0, 0, '0, 1, 1, 32'h66, 1);
    apply_stimulus(0, 0, '0, 0, 0, '0, 1);
    idle(1);

    $display("[TB] pointer wrap");
    do_reset();
    for (int i = 0; i < 10; i++)
      apply_stimulus(1, 1, 32'(32'h100 + 4 * i), i > 0, 1, 32'(32'hC00 + i), 0);
    apply_stimulus(0, 0, '0, 1, 1, 32'hCFF, 0);
    idle(2);

    $display("[TB] reset mid-flight");
    apply_stimulus(1, 1, 32'h200, 0, 0, '0, 0);
    apply_stimulus(1, 1, 32'h204, 0, 0, '0, 0);
    do_reset();
    apply_stimulus(0, 0, '0, 1, 1, 32'h77, 0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        apply_stimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 75, $urandom(),
                       $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 75, $urandom(),
                       $urandom_range(0, 99) < 5);
      end
    end
    pops_left = m_q.size();
    for (int i = 0; i < pops_left; i++) apply_stimulus(0, 0, '0, 1, 1, $urandom(), 0);
    idle(2);

    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
